// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and baud divisor helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Nearest-integer clocks per bit, so the bit period error stays below half a clock.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; reset value chosen per use (idle level).
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, one-entry valid/ready output.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rxs
// START | counting to mid start bit; line high again there means a glitch
// DATA  | sampling 8 data bits LSB first, one per bit period
// STOP  | sampling the stop bit; low means framing error
// BREAK | line held low after a framing error, wait for it to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 16_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam int              HALF     = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'(HALF - 1);
    localparam logic [2:0]      IDX_LAST = 3'(DATA_BITS - 1);

    logic                 rxs;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] sh;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxs)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        cnt   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rxs) begin
                            idx   <= '0;
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        sh  <= {rxs, sh[DATA_BITS-1:1]};
                        if (idx == IDX_LAST)
                            state <= STOP;
                        else
                            idx <= idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            // A byte being drained this cycle frees the holding register.
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= sh;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: latency, glitch, framing, overrun, reset, back-to-back.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int t_start = 0;

    logic [7:0] rx_q[$];
    int         acc_cyc[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         both_cnt = 0;
    int         ov_cyc = 0;
    int         rise_cyc = 0;
    int         run_len = 0;
    int         last_run = 0;
    logic       valid_d = 1'b0;

    uart_rx #(
        .CLK_HZ       (16_000_000),
        .BAUD         (115_200),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            valid_d = 1'b0;
            run_len = 0;
        end else begin
            if (rx_valid && rx_ready) begin
                rx_q.push_back(rx_data);
                acc_cyc.push_back(cyc);
            end
            if (rx_valid && !valid_d)
                rise_cyc = cyc;
            if (rx_valid)
                run_len++;
            else if (valid_d) begin
                last_run = run_len;
                run_len  = 0;
            end
            if (frame_err) fe_cnt++;
            if (overrun) begin
                ov_cnt++;
                ov_cyc = cyc;
            end
            if (frame_err && overrun) both_cnt++;
            valid_d = rx_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(data[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] q_at(input int i);
        if (i < rx_q.size())
            return rx_q[i];
        return 8'hxx;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int q0;
        int fe0;
        int ov0;

        rst      = 1'b1;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        #1;
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);

        // 1: single byte, latency and pulse width
        rx_ready = 1'b1;
        q0 = rx_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h55, 1'b1);
        idle(4);
        check("t1_count", rx_q.size() - q0, 1);
        check("t1_data", q_at(q0), 8'h55);
        check("t1_latency", rise_cyc - t_start, 155);
        check("t1_width", last_run, 1);
        check("t1_ferr", fe_cnt - fe0, 0);
        check("t1_ovr", ov_cnt - ov0, 0);

        // 2: short low glitch rejected, following frame fine
        q0 = rx_q.size(); fe0 = fe_cnt;
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(40);
        check("t2_glitch_none", rx_q.size() - q0, 0);
        check("t2_glitch_ferr", fe_cnt - fe0, 0);
        check("t2_glitch_valid", rx_valid, 0);
        send_frame(8'hC3, 1'b1);
        idle(4);
        check("t2_count", rx_q.size() - q0, 1);
        check("t2_data", q_at(q0), 8'hC3);

        // 3: framing error, held-low line, recovery
        q0 = rx_q.size(); fe0 = fe_cnt;
        send_frame(8'hA3, 1'b0);
        rxd = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("t3_ferr", fe_cnt - fe0, 1);
        check("t3_no_byte", rx_q.size() - q0, 0);
        idle(20);
        send_frame(8'h3C, 1'b1);
        idle(4);
        check("t3_ferr_total", fe_cnt - fe0, 1);
        check("t3_count", rx_q.size() - q0, 1);
        check("t3_data", q_at(q0), 8'h3C);

        // 4: overrun while holding register full
        rx_ready = 1'b0;
        q0 = rx_q.size(); ov0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(5);
        check("t4_valid", rx_valid, 1);
        check("t4_hold", rx_data, 8'h11);
        check("t4_ovr", ov_cnt - ov0, 1);
        check("t4_ovr_time", ov_cyc - t_start, 155);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_count", rx_q.size() - q0, 1);
        check("t4_consumed", q_at(q0), 8'h11);
        check("t4_drop", rx_valid, 0);

        // 5: reset mid-frame with a byte pending
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1);
        idle(4);
        check("t5_pending_valid", rx_valid, 1);
        check("t5_pending_data", rx_data, 8'h5A);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++)
            drive_bit(1'b0);
        rxd = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_valid", rx_valid, 0);
        check("t5_rst_data", rx_data, 0);
        check("t5_rst_ferr", frame_err, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);
        rx_ready = 1'b1;
        q0 = rx_q.size(); fe0 = fe_cnt;
        send_frame(8'h96, 1'b1);
        idle(4);
        check("t5_count", rx_q.size() - q0, 1);
        check("t5_data", q_at(q0), 8'h96);
        check("t5_ferr", fe_cnt - fe0, 0);

        // 6: back-to-back frames, no idle gap
        q0 = rx_q.size(); ov0 = ov_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h80, 1'b1);
        idle(10);
        check("t6_count", rx_q.size() - q0, 3);
        check("t6_data0", q_at(q0), 8'h00);
        check("t6_data1", q_at(q0 + 1), 8'hFF);
        check("t6_data2", q_at(q0 + 2), 8'h80);
        if (acc_cyc.size() >= q0 + 3) begin
            check("t6_gap01", acc_cyc[q0 + 1] - acc_cyc[q0], 160);
            check("t6_gap12", acc_cyc[q0 + 2] - acc_cyc[q0 + 1], 160);
        end
        check("t6_ovr", ov_cnt - ov0, 0);

        check("flags_exclusive", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
